// File: rtl/fpu_resp_scheduler.sv
// fpu_resp_scheduler
// Merges the responses of two FPU result sources onto one valid/ready
// output stream. Each source has its own FIFO_DEPTH-entry buffer. When
// both buffers hold data, a round-robin pointer picks the source. A stalled
// output beat is locked so that the data, flags and source index stay
// stable until the beat is accepted.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   resp_valid{0,1}_i              source valid
//   resp_ready{0,1}_o              source buffer can accept (registered count)
//   resp_rdata{0,1}_i              source result data
//   resp_flag{0,1}_i               source result flags
//   data_r_valid_o / data_r_ready_i   merged output handshake
//   data_r_rdata_o / data_r_flag_o    merged data/flags (zero when idle)
//   data_r_src_o                   source index of current beat (zero when idle)
module fpu_resp_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resp_valid0_i,
    input  logic                  resp_valid1_i,
    output logic                  resp_ready0_o,
    output logic                  resp_ready1_o,
    input  logic [DATA_WIDTH-1:0] resp_rdata0_i,
    input  logic [DATA_WIDTH-1:0] resp_rdata1_i,
    input  logic [FLAG_WIDTH-1:0] resp_flag0_i,
    input  logic [FLAG_WIDTH-1:0] resp_flag1_i,
    output logic                  data_r_valid_o,
    input  logic                  data_r_ready_i,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [FLAG_WIDTH-1:0] data_r_flag_o,
    output logic                  data_r_src_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_WIDTH + FLAG_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // Per-source buffer state; entry layout is {flag, data}.
    logic [EW-1:0] r_mem [2][FIFO_DEPTH];
    logic [PW-1:0] r_wp  [2];
    logic [PW-1:0] r_rp  [2];
    logic [CW-1:0] r_cnt [2];

    logic r_rr;
    logic r_lock;
    logic r_lock_src;

    logic [1:0]    w_in_valid;
    logic [EW-1:0] w_in_ent [2];
    logic [1:0]    w_ready;
    logic [1:0]    w_ne;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic          w_sel;
    logic          w_out_valid;
    logic          w_fire;
    logic [EW-1:0] w_head;

    assign w_in_valid  = {resp_valid1_i, resp_valid0_i};
    assign w_in_ent[0] = {resp_flag0_i, resp_rdata0_i};
    assign w_in_ent[1] = {resp_flag1_i, resp_rdata1_i};

    always_comb begin
        w_ready = '0;
        w_ne    = '0;
        w_push  = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            w_ready[s] = (r_cnt[s] != FULL);
            w_ne[s]    = (r_cnt[s] != '0);
            w_push[s]  = w_in_valid[s] & w_ready[s];
        end
    end

    // Selection: a held (locked) beat wins; otherwise the only non-empty
    // buffer, or the round-robin choice when both hold data.
    always_comb begin
        w_sel = r_rr;
        if (r_lock) begin
            w_sel = r_lock_src;
        end else if (w_ne[0] ^ w_ne[1]) begin
            w_sel = w_ne[1];
        end
    end

    assign w_out_valid = |w_ne;
    assign w_fire      = w_out_valid & data_r_ready_i;
    assign w_pop[0]    = w_fire & ~w_sel;
    assign w_pop[1]    = w_fire & w_sel;
    assign w_head      = r_mem[w_sel][r_rp[w_sel]];

    assign resp_ready0_o  = w_ready[0];
    assign resp_ready1_o  = w_ready[1];
    assign data_r_valid_o = w_out_valid;
    assign data_r_rdata_o = w_out_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign data_r_flag_o  = w_out_valid ? w_head[EW-1:DATA_WIDTH] : '0;
    assign data_r_src_o   = w_out_valid & w_sel;

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_mem[s][r_wp[s]] <= w_in_ent[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < 2; s++) begin
                r_wp[s]  <= '0;
                r_rp[s]  <= '0;
                r_cnt[s] <= '0;
            end
            r_rr       <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_src <= 1'b0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_wp[s] <= r_wp[s] + 1'b1;
                end
                if (w_pop[s]) begin
                    r_rp[s] <= r_rp[s] + 1'b1;
                end
                case ({w_push[s], w_pop[s]})
                    2'b10:   r_cnt[s] <= r_cnt[s] + 1'b1;
                    2'b01:   r_cnt[s] <= r_cnt[s] - 1'b1;
                    default: r_cnt[s] <= r_cnt[s];
                endcase
            end
            if (w_fire) begin
                r_rr <= ~w_sel;
            end
            // A stalled beat keeps its source. The lock drops in the
            // handshake cycle.
            r_lock     <= w_out_valid & ~data_r_ready_i;
            r_lock_src <= w_sel;
        end
    end

endmodule

// File: tb/tb_fpu_resp_scheduler.sv
// Directed and short randomized bench for fpu_resp_scheduler (default
// parameters: 32-bit data, 8-bit flags, depth 2).
module tb_fpu_resp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy;
    logic        ready0, ready1;
    logic [31:0] d0, d1;
    logic [7:0]  f0, f1;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_flag;
    logic        out_src;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_resp_scheduler #(.DATA_WIDTH(32), .FLAG_WIDTH(8), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .resp_valid0_i  (v0),
        .resp_valid1_i  (v1),
        .resp_ready0_o  (ready0),
        .resp_ready1_o  (ready1),
        .resp_rdata0_i  (d0),
        .resp_rdata1_i  (d1),
        .resp_flag0_i   (f0),
        .resp_flag1_i   (f1),
        .data_r_valid_o (out_valid),
        .data_r_ready_i (rdy),
        .data_r_rdata_o (out_data),
        .data_r_flag_o  (out_flag),
        .data_r_src_o   (out_src)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                              input logic [7:0] f, input logic s);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_data"},  out_data,  d);
        check({tag, "_flag"},  out_flag,  f);
        check({tag, "_src"},   out_src,   s);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [31:0] exp_d [2];
    logic        exp_src;
    logic        p0, p1;
    logic [39:0] head;
    int          n0, n1;

    initial begin
        // Reset with live inputs: nothing presented during reset may be stored.
        rst = 1'b1; rdy = 1'b0;
        v0 = 1'b1; d0 = 32'h55; f0 = 8'h05;
        v1 = 1'b1; d1 = 32'h66; f1 = 8'h06;
        tick; tick;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
        expect_out("reset", 1'b0, 32'h0, 8'h0, 1'b0);
        check("reset_ready0", ready0, 1'b1);
        check("reset_ready1", ready1, 1'b1);
        tick;
        check("rst_nostore", out_valid, 1'b0);

        // Simultaneous push on both sources: src0 first (rr=0), then src1.
        v0 = 1'b1; d0 = 32'hA; f0 = 8'h01;
        v1 = 1'b1; d1 = 32'hB; f1 = 8'h02;
        tick;
        v0 = 1'b0; v1 = 1'b0;
        expect_out("both_a", 1'b1, 32'hA, 8'h01, 1'b0);
        tick;
        expect_out("both_b", 1'b1, 32'hB, 8'h02, 1'b1);
        tick;
        expect_out("both_idle", 1'b0, 32'h0, 8'h0, 1'b0);

        // Stall on a src1 beat while src0 fills. The locked beat holds even
        // though rr=0 would otherwise pick src0.
        rdy = 1'b0;
        v1 = 1'b1; d1 = 32'hB; f1 = 8'h07;
        tick;
        v1 = 1'b0;
        expect_out("lock_a", 1'b1, 32'hB, 8'h07, 1'b1);
        v0 = 1'b1; d0 = 32'h10; f0 = 8'h10;
        tick;
        d0 = 32'h11; f0 = 8'h11;
        tick;
        v0 = 1'b0;
        check("lock_full0", ready0, 1'b0);
        expect_out("lock_b", 1'b1, 32'hB, 8'h07, 1'b1);
        tick;
        expect_out("lock_c", 1'b1, 32'hB, 8'h07, 1'b1);
        rdy = 1'b1;
        tick;
        expect_out("lock_d", 1'b1, 32'h10, 8'h10, 1'b0);
        tick;
        expect_out("lock_e", 1'b1, 32'h11, 8'h11, 1'b0);
        tick;
        check("lock_idle", out_valid, 1'b0);

        // Single source overrun: third beat waits upstream until space opens.
        rdy = 1'b0;
        v0 = 1'b1; d0 = 32'h1; f0 = 8'h21;
        tick;
        check("full_rdy_1", ready0, 1'b1);
        check("full_head_1", out_data, 32'h1);
        d0 = 32'h2; f0 = 8'h22;
        tick;
        check("full_rdy_2", ready0, 1'b0);
        d0 = 32'h3; f0 = 8'h23;
        tick;
        check("full_rdy_3", ready0, 1'b0);
        expect_out("full_hold", 1'b1, 32'h1, 8'h21, 1'b0);
        rdy = 1'b1;
        tick;
        expect_out("full_o2", 1'b1, 32'h2, 8'h22, 1'b0);
        check("full_rdy_4", ready0, 1'b1);
        tick;
        v0 = 1'b0;
        expect_out("full_o3", 1'b1, 32'h3, 8'h23, 1'b0);
        tick;
        check("full_idle", out_valid, 1'b0);

        // One src1 beat to bring rr back to 0.
        v1 = 1'b1; d1 = 32'hC; f1 = 8'h00;
        tick;
        v1 = 1'b0;
        expect_out("rr_fix", 1'b1, 32'hC, 8'h00, 1'b1);
        tick;
        check("rr_fix_idle", out_valid, 1'b0);

        // Both buffers full, downstream always ready: strict alternation.
        rdy = 1'b0;
        v0 = 1'b1; d0 = 32'h20; f0 = 8'h00;
        v1 = 1'b1; d1 = 32'h30; f1 = 8'h00;
        tick;
        d0 = 32'h21; d1 = 32'h31;
        tick;
        check("alt_full0", ready0, 1'b0);
        check("alt_full1", ready1, 1'b0);
        d0 = 32'h22; d1 = 32'h32;
        exp_d[0] = 32'h20; exp_d[1] = 32'h30; exp_src = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_out("alt", 1'b1, exp_d[exp_src], 8'h00, exp_src);
            p0 = ready0; p1 = ready1;
            tick;
            if (p0) d0 = d0 + 32'h1;
            if (p1) d1 = d1 + 32'h1;
            exp_d[exp_src] = exp_d[exp_src] + 32'h1;
            exp_src = ~exp_src;
        end

        // Fill both, then reset: everything buffered is discarded.
        rdy = 1'b0;
        tick; tick;
        check("pre_rst_full0", ready0, 1'b0);
        check("pre_rst_full1", ready1, 1'b0);
        rst = 1'b1; d0 = 32'hEE; d1 = 32'hEF;
        tick;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
        expect_out("midrst", 1'b0, 32'h0, 8'h0, 1'b0);
        check("midrst_ready0", ready0, 1'b1);
        check("midrst_ready1", ready1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("midrst_quiet", out_valid, 1'b0);
        end

        // Random traffic against per-source scoreboards.
        n0 = 0; n1 = 0;
        for (int i = 0; i < 340; i++) begin
            if (i < 300) begin
                v0 = 1'($urandom_range(0, 1));
                v1 = 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
            end
            d0 = 32'h1000_0000 + 32'(n0); f0 = 8'($urandom);
            d1 = 32'h2000_0000 + 32'(n1); f1 = 8'($urandom);
            check("rnd_ready0", ready0, q0.size() != 2);
            check("rnd_ready1", ready1, q1.size() != 2);
            check("rnd_valid", out_valid, (q0.size() + q1.size()) != 0);
            p0 = v0 & ready0;
            p1 = v1 & ready1;
            if (out_valid && rdy) begin
                if (out_src == 1'b0) begin
                    check("rnd_q0_nonempty", q0.size() != 0, 1'b1);
                    if (q0.size() != 0) begin
                        head = q0.pop_front();
                        check("rnd_beat0", {out_flag, out_data}, head);
                    end
                end else begin
                    check("rnd_q1_nonempty", q1.size() != 0, 1'b1);
                    if (q1.size() != 0) begin
                        head = q1.pop_front();
                        check("rnd_beat1", {out_flag, out_data}, head);
                    end
                end
            end
            tick;
            if (p0) begin q0.push_back({f0, d0}); n0++; end
            if (p1) begin q1.push_back({f1, d1}); n1++; end
        end
        check("rnd_drained", q0.size() + q1.size(), 0);
        check("rnd_final_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
